// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and programmable baud divisor.
// Optional drain interrupt and CTRL register are built when UART_TX_IRQ_EN is defined.
module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic            wr, rd;
    logic            sel_data, sel_status, sel_div, sel_ctrl;
    logic            push_req, push_ok, pop;
    logic            full, empty, busy;
    logic            overflow;
    logic [15:0]     div;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [31:0]     rdata;

    state_t          state, state_d;
    logic [15:0]     cnt, cnt_d, eff_div, eff_div_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            tx_d, at_end;

    // Address bits [1:0] and the upper data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

    assign wr         = en_i && (we_i != 4'd0);
    assign rd         = en_i && (we_i == 4'd0);
    assign sel_data   = (addr_i[3:2] == 2'd0);
    assign sel_status = (addr_i[3:2] == 2'd1);
    assign sel_div    = (addr_i[3:2] == 2'd2);
    assign sel_ctrl   = (addr_i[3:2] == 2'd3);

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign push_req = wr && sel_data;
    assign push_ok  = push_req && !full;

    // NOTE: the FIFO storage has no reset; pointers and count define validity, so old contents are harmless.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_i[7:0];
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DEFAULT_DIV[15:0];
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full)        overflow <= 1'b1;
            else if (wr && sel_status)   overflow <= 1'b0;
            if (wr && sel_div)           div <= data_i[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            eff_div <= 16'd1;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            eff_div <= eff_div_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            tx_o    <= tx_d;
        end
    end

    assign at_end = (cnt == eff_div - 16'd1);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        eff_div_d = eff_div;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr];
                    eff_div_d = (div == 16'd0) ? 16'd1 : div;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (at_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            DATA: begin
                if (at_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            STOP: begin
                if (at_end) begin
                    // Back-to-back frames: reload straight into START with no idle bit.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = mem[rd_ptr];
                        eff_div_d = (div == 16'd0) ? 16'd1 : div;
                        cnt_d     = '0;
                        state_d   = START;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

`ifdef UART_TX_IRQ_EN
    logic irq_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr && sel_ctrl) irq_enable <= data_i[0];
            irq_o <= irq_enable && empty && !busy;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (sel_status) begin
            rdata[0]         = full;
            rdata[1]         = empty;
            rdata[2]         = busy;
            rdata[3]         = overflow;
            rdata[8 +: AW+1] = count;
        end else if (sel_div) begin
            rdata[15:0] = div;
        end else if (sel_ctrl) begin
`ifdef UART_TX_IRQ_EN
            rdata[0] = irq_enable;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   data_o <= '0;
        else if (rd) data_o <= rdata;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the core data bus.
- Sits downstream of the bus address decoder and consumes byte writes that the CPU currently sends to the character-output registers.
- Buffers bytes in a FIFO and serialises each one as 8N1 on a single TX line at a programmable baud divisor.
- Gives the platform a real serial console in place of simulation-only character printing.

Parameters:
- FIFO_DEPTH, 16, number of byte entries in the TX FIFO; power of 2, minimum 2.
- DEFAULT_DIV, 868, reset value of the baud divisor in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  in  1  system clock; all logic is posedge.
- reset  in  1  asynchronous, active-high reset.
- en_i  in  1  bus select, already decoded for this peripheral.
- we_i  in  4  byte write enables; any nonzero value means a write.
- addr_i  in  4  byte offset of the register.
- data_i  in  32  write data.
- data_o  out  32  read data, registered.
- tx_o  out  1  serial output; idles high.
- irq_o  out  1  interrupt request; see Optional Feature.

Behaviour:
- Register map (word offsets; addr_i[1:0] ignored):
  - 0x0 DATA, write-only: data_i[7:0] is pushed to the FIFO. Reads return 0.
  - 0x4 STATUS, read: bit0 fifo_full, bit1 fifo_empty, bit2 busy (shifter active), bit3 overflow (sticky), bits[8+:5] fifo count, all other bits 0. Any write to STATUS clears overflow.
  - 0x8 DIV, read/write: bits[15:0] are the divisor, upper bits read 0.
  - 0xC CTRL: bit0 irq_enable (present only with the macro; reads 0 otherwise).
- Read timing:
  - data_o is updated on the posedge where en_i=1 and we_i=0, so data is valid the cycle after the request, matching the RAM timing.
  - data_o holds its value otherwise.
- Reset values:
  - data_o=0, tx_o=1, irq_o=0.
  - FIFO empty (count=0), overflow=0, DIV=DEFAULT_DIV, irq_enable=0.
  - FSM in IDLE.
  - Reset asserted mid-frame forces tx_o=1 immediately and discards the FIFO contents.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(FIFO_DEPTH) bits that wrap modulo the depth.
  - Count is $clog2(FIFO_DEPTH)+1 bits.
  - A push is accepted only if count<FIFO_DEPTH at the start of the cycle. A push while full is dropped and sets overflow; the FIFO is unchanged.
  - Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. On a full FIFO the push is still rejected, even though a pop occurs that cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is not empty, pop the head into the shift register, latch the divisor as eff_div = (DIV==0 ? 1 : DIV), clear the baud counter, then go to START.
  - START: tx_o=0 for eff_div cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift[0] for eff_div cycles, then shift right. After bit 7 go to STOP. Bits are sent LSB first.
  - STOP: tx_o=1 for eff_div cycles. Then, if the FIFO is not empty, pop the next byte and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*eff_div cycles. busy=1 in every state except IDLE.
- A DIV write during a frame takes effect only at the start of the next frame.
- tx_o is driven from a flop, so there are no combinational glitches.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- When defined:
  - The CTRL.irq_enable flop exists.
  - irq_o is registered and equals irq_enable & fifo_empty & ~busy, i.e. all data has fully drained.
  - The interrupt is level-sensitive and is cleared by pushing data or clearing irq_enable.
- When undefined:
  - irq_o is tied to 0.
  - The CTRL register is absent, so writes are ignored and reads return 0.

Test Plan:
- Reset, then read STATUS and DIV -> STATUS=0x00000002, DIV=868, tx_o=1.
- Write DIV=4, then DATA=0x55 -> tx_o shows 4 cycles low, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 4 cycles high. Total 40 cycles; busy then drops and STATUS=0x2.
- DIV=2, write 0x41, 0x42, 0x43 back-to-back -> three contiguous 20-cycle frames with no idle gap. STATUS.count reads 2 just after the first pop; received bytes are A, B, C in order.
- DIV=1000, write 17 bytes -> first byte popped, 16 buffered, 17th accepted. An 18th write -> overflow=1, count=16. Writing STATUS clears overflow.
- DIV=0, write 0xFF -> 10-cycle frame (divisor treated as 1). Writing DIV=8 mid-frame -> current frame unchanged, next frame 80 cycles.
- Assert reset at cycle 15 of a DIV=4 frame -> tx_o=1 in the same cycle, FIFO empty. With UART_TX_IRQ_EN defined, irq_enable=1 and the drain completing -> irq_o=1 one cycle after busy falls.
